// File: rtl/unpacked_array_deser.sv
// -----------------------------------------------------------------------------
// unpacked_array_deser
//
// Serial-to-unpacked-array deserializer. Bits arriving on din (qualified by
// din_valid) are collected into M-element words. Each completed word is
// presented on the unpacked output array q[M] with a valid/ready handshake.
// q[0] holds the first bit received. A completed word that finds q still
// occupied (q_valid && !q_ready) is dropped and the sticky ovf flag is set.
//
// Optional feature macro: UAD_PARITY_EN
//   defined   : frame is M+1 bits, the last bit is an even-parity bit over the
//               M data bits; parity_err is loaded with each accepted word.
//   undefined : frame is M bits, parity_err is constant 0.
//
// Parameters:
//   M           elements per word (>= 2)
//
// Ports:
//   clock       in   sole clock, all state on rising edge
//   reset       in   asynchronous, active-high reset
//   din         in   serial data bit
//   din_valid   in   din is sampled this cycle
//   align       in   synchronous frame restart, discards any partial word
//   q[M]        out  completed word (registered)
//   q_valid     out  q holds an unconsumed word (registered)
//   q_ready     in   consumer accepts q when q_valid && q_ready
//   ovf         out  sticky: a completed word was dropped (registered)
//   ovf_clr     in   synchronous clear of ovf (a same-cycle set wins)
//   parity_err  out  parity mismatch of the word held in q
// -----------------------------------------------------------------------------
module unpacked_array_deser #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    input  logic align,
    output logic q [M],
    output logic q_valid,
    input  logic q_ready,
    output logic ovf,
    input  logic ovf_clr,
    output logic parity_err
);

`ifdef UAD_PARITY_EN
    localparam int F = M + 1;
`else
    localparam int F = M;
`endif
    localparam int CW = $clog2(F + 1);

`ifdef UAD_PARITY_EN
    // Even parity: the XOR of data and parity bit must be 0; returns 1 on mismatch.
    function automatic logic parity_mismatch(input logic [M-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction
`endif

    // The final frame bit is never stored: it is taken straight from din on
    // the completing cycle, so the shift register holds only F-1 slots.
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic [F-2:0]  shift_r;
    logic [F-2:0]  shift_nx_s;
    logic [F-1:0]  frame_s;
    logic [M-1:0]  data_s;
    logic          q_r [M];
    logic          q_nx_s [M];
    logic          q_valid_r;
    logic          q_valid_nx_s;
    logic          ovf_r;
    logic          ovf_nx_s;
    logic          perr_r;
    logic          perr_nx_s;
    logic          perr_s;
    logic          sample_s;
    logic          done_s;
    logic          accept_s;
    logic          drop_s;

    // Frame assembly, completion/handshake decisions and next-state values.
    always_comb begin
        sample_s     = 1'b0;
        done_s       = 1'b0;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        cnt_nx_s     = cnt_r;
        shift_nx_s   = shift_r;
        q_valid_nx_s = q_valid_r;
        ovf_nx_s     = ovf_r;
        perr_nx_s    = perr_r;
        frame_s      = {din, shift_r};
        data_s       = frame_s[M-1:0];
`ifdef UAD_PARITY_EN
        perr_s       = parity_mismatch(data_s, frame_s[M]);
`else
        perr_s       = 1'b0;
`endif
        for (int i = 0; i < M; i++) begin
            q_nx_s[i] = q_r[i];
        end

        // align outranks din_valid: the bit of an aligning cycle is ignored.
        if (align) begin
            sample_s = 1'b0;
        end else begin
            sample_s = din_valid;
        end

        if (sample_s && (cnt_r == CW'(F - 1))) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end

        // A word may enter q when q is empty or is being consumed this cycle.
        if (done_s) begin
            if (!q_valid_r || q_ready) begin
                accept_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end

        // Bit counter.
        if (align) begin
            cnt_nx_s = {CW{1'b0}};
        end else if (done_s) begin
            cnt_nx_s = {CW{1'b0}};
        end else if (sample_s) begin
            cnt_nx_s = cnt_r + CW'(1);
        end else begin
            cnt_nx_s = cnt_r;
        end

        // Shift slot write, decoded per slot to keep the index width exact.
        for (int i = 0; i < F - 1; i++) begin
            if (sample_s && (cnt_r == CW'(i))) begin
                shift_nx_s[i] = din;
            end else begin
                shift_nx_s[i] = shift_r[i];
            end
        end

        // Output word and its parity status move together.
        if (accept_s) begin
            for (int i = 0; i < M; i++) begin
                q_nx_s[i] = data_s[i];
            end
            q_valid_nx_s = 1'b1;
            perr_nx_s    = perr_s;
        end else if (q_valid_r && q_ready) begin
            q_valid_nx_s = 1'b0;
        end else begin
            q_valid_nx_s = q_valid_r;
        end

        // Sticky overflow; a drop in the clearing cycle keeps it set.
        if (drop_s) begin
            ovf_nx_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nx_s = 1'b0;
        end else begin
            ovf_nx_s = ovf_r;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r     <= {CW{1'b0}};
            shift_r   <= {(F-1){1'b0}};
            q_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
            perr_r    <= 1'b0;
            for (int i = 0; i < M; i++) begin
                q_r[i] <= 1'b0;
            end
        end else begin
            cnt_r     <= cnt_nx_s;
            shift_r   <= shift_nx_s;
            q_valid_r <= q_valid_nx_s;
            ovf_r     <= ovf_nx_s;
            perr_r    <= perr_nx_s;
            for (int i = 0; i < M; i++) begin
                q_r[i] <= q_nx_s[i];
            end
        end
    end

    assign q          = q_r;
    assign q_valid    = q_valid_r;
    assign ovf        = ovf_r;
`ifdef UAD_PARITY_EN
    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_unpacked_array_deser.sv
// -----------------------------------------------------------------------------
// tb_unpacked_array_deser
//
// Self-checking bench for unpacked_array_deser (M = 4). A queue-based model
// collects bits into frames, and tracks the pending word, its valid flag, the
// sticky overflow flag and the parity flag. Directed scenarios are followed by
// a randomized run. Honours UAD_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_unpacked_array_deser;

    localparam int M = 4;
`ifdef UAD_PARITY_EN
    localparam int F = M + 1;
`else
    localparam int F = M;
`endif

    logic clock = 1'b0;
    logic reset;
    logic din;
    logic din_valid;
    logic align;
    logic q_s [M];
    logic q_valid;
    logic q_ready;
    logic ovf;
    logic ovf_clr;
    logic parity_err;

    // Reference model state.
    bit           part[$];
    logic [M-1:0] mq;
    logic         mv;
    logic         movf;
    logic         mperr;

    int n_cmp = 0;
    int n_err = 0;

    unpacked_array_deser #(.M(M)) dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .align      (align),
        .q          (q_s),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .parity_err (parity_err)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] qvec();
        logic [M-1:0] v;
        for (int i = 0; i < M; i++) v[i] = q_s[i];
        return v;
    endfunction

    task automatic model_reset();
        part.delete();
        mq    = '0;
        mv    = 1'b0;
        movf  = 1'b0;
        mperr = 1'b0;
    endtask

    task automatic model_step(input logic dv, input logic d, input logic al,
                              input logic rdy, input logic clr);
        logic         done;
        logic         drop;
        logic [M-1:0] w;
        logic         pe;
        done = 1'b0;
        w    = '0;
        pe   = 1'b0;
        if (al) begin
            part.delete();
        end else if (dv) begin
            part.push_back(d);
            if (part.size() == F) begin
                done = 1'b1;
                for (int i = 0; i < M; i++) w[i] = part[i];
`ifdef UAD_PARITY_EN
                pe = ((^w) != part[M]);
`endif
                part.delete();
            end
        end
        drop = done && mv && !rdy;
        if (done && !drop) begin
            mq    = w;
            mv    = 1'b1;
            mperr = pe;
        end else if (mv && rdy) begin
            mv = 1'b0;
        end
        if (drop) movf = 1'b1;
        else if (clr) movf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    32'(qvec()),     32'(mq));
        chk({tag, ".qv"},   32'(q_valid),    32'(mv));
        chk({tag, ".ovf"},  32'(ovf),        32'(movf));
        chk({tag, ".perr"}, 32'(parity_err), 32'(mperr));
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic cycle(input logic dv, input logic d, input logic al,
                         input logic rdy, input logic clr, input string tag);
        din_valid = dv;
        din       = d;
        align     = al;
        q_ready   = rdy;
        ovf_clr   = clr;
        @(posedge clock);
        model_step(dv, d, al, rdy, clr);
        #1;
        check_all(tag);
    endtask

    // Send w[0] first; the last frame bit (data or parity) uses rdy_last.
    task automatic send_word(input logic [M-1:0] w, input logic rdy_body, input logic rdy_last);
`ifdef UAD_PARITY_EN
        for (int i = 0; i < M; i++) cycle(1'b1, w[i], 1'b0, rdy_body, 1'b0, "word");
        cycle(1'b1, ^w, 1'b0, rdy_last, 1'b0, "par");
`else
        for (int i = 0; i < M - 1; i++) cycle(1'b1, w[i], 1'b0, rdy_body, 1'b0, "word");
        cycle(1'b1, w[M-1], 1'b0, rdy_last, 1'b0, "last");
`endif
    endtask

    initial begin
        reset     = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        align     = 1'b0;
        q_ready   = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // Single word, consumer ready: q valid for exactly one cycle.
        send_word(4'b1101, 1'b1, 1'b1);
        chk("t1.q",  32'(qvec()),  32'h0000000d);
        chk("t1.qv", 32'(q_valid), 32'h00000001);
        chk("t1.ovf", 32'(ovf),    32'h00000000);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t1.idle");
        chk("t1.qv_fall", 32'(q_valid), 32'h00000000);

        // Back-to-back words under back-pressure: second word dropped.
        send_word(4'b0011, 1'b0, 1'b0);
        send_word(4'b1010, 1'b0, 1'b0);
        chk("t2.q",   32'(qvec()), 32'h00000003);
        chk("t2.ovf", 32'(ovf),    32'h00000001);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t2.drain");
        chk("t2.qv_fall", 32'(q_valid), 32'h00000000);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t2.clr");
        chk("t2.ovf_clr", 32'(ovf), 32'h00000000);

        // Completion coinciding with a handshake: new word replaces old.
        send_word(4'b0110, 1'b0, 1'b0);
        send_word(4'b1001, 1'b0, 1'b1);
        chk("t3.q",   32'(qvec()),  32'h00000009);
        chk("t3.qv",  32'(q_valid), 32'h00000001);
        chk("t3.ovf", 32'(ovf),     32'h00000000);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3.drain");

        // align discards a partial word and the bit presented with it.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t4.p0");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t4.p1");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "t4.align");
        send_word(4'b1000, 1'b0, 1'b0);
        chk("t4.q", 32'(qvec()), 32'h00000008);

        // Asynchronous reset mid-word with a pending word.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t5.b0");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5.b1");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t5.b2");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("t5.qv_rst", 32'(q_valid), 32'h00000000);
        chk("t5.q_rst",  32'(qvec()),  32'h00000000);
        @(negedge clock);
        reset = 1'b0;
        send_word(4'b0101, 1'b1, 1'b1);
        chk("t5.q_fresh", 32'(qvec()), 32'h00000005);

`ifdef UAD_PARITY_EN
        // Correct parity, then wrong parity on the same data.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "p.a0");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "p.a1");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "p.a2");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "p.a3");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "p.a4");
        chk("p.ok", 32'(parity_err), 32'h00000000);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "p.b0");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "p.b1");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "p.b2");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "p.b3");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "p.b4");
        chk("p.bad",   32'(parity_err), 32'h00000001);
        chk("p.bad_q", 32'(qvec()),     32'h0000000d);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                  "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
